// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared states, opcodes and select encodings for the control FSM
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BLT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_OR  = 3'b011;
    localparam logic [2:0] ALUOP_XOR = 3'b100;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Opcodes 1011..1110 are the only holes in the map.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_op_decoder.sv
// rtl/multicycle_control_fsm_alu_op_decoder.sv - state/opcode to ALU control map
module alu_op_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  logic [3:0] state,
    input  logic [2:0] funct,
    output logic [2:0] alu_op,
    output logic       alu_en,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b
);

    always_comb begin
        alu_op    = ALUOP_ADD;
        alu_en    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_REG;
        case (state)
            S_FETCH: begin
                alu_en    = 1'b1;
                alu_src_b = SRCB_ONE;
            end
            S_EXEC_R: begin
                // R-type opcodes 0000..0100 carry the ALUOp directly in their low bits
                alu_op    = (funct <= ALUOP_XOR) ? funct : ALUOP_ADD;
                alu_en    = 1'b1;
                alu_src_a = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_en    = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_BRANCH: begin
                alu_op    = ALUOP_SUB;
                alu_en    = 1'b1;
                alu_src_a = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int ALUOPW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    Opcode,
    input  logic              Z,
    input  logic              N,
    input  logic              MemReady,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              ALUEn,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic              PCWrite,
    output logic [1:0]        PCSrc,
    output logic              IRWrite,
    output logic              AddrSrc,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              RegWrite,
    output logic              WBSrc,
    output logic              Halted,
    output logic              Illegal
);

    state_t state_q;
    state_t state_nxt;

    logic [2:0] dec_alu_op;
    logic       dec_alu_en;
    logic       dec_alu_src_a;
    logic [1:0] dec_alu_src_b;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_nxt = S_EXEC_R;
                    OP_ADDI:        state_nxt = S_EXEC_I;
                    OP_LW, OP_SW:   state_nxt = S_MEM_ADDR;
                    OP_BEQ, OP_BLT: state_nxt = S_BRANCH;
                    OP_JMP:         state_nxt = S_JUMP;
                    OP_HALT:        state_nxt = S_HALT;
                    default:        state_nxt = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
            S_MEM_ADDR: state_nxt = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_nxt = MemReady ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   state_nxt = MemReady ? S_FETCH : S_MEM_WR;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Decoding the next state lets the Moore outputs be registered alongside it.
    alu_op_decoder u_alu_op_decoder (
        .state     (state_nxt),
        .funct     (Opcode[2:0]),
        .alu_op    (dec_alu_op),
        .alu_en    (dec_alu_en),
        .alu_src_a (dec_alu_src_a),
        .alu_src_b (dec_alu_src_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ALUOp    <= '0;
            ALUEn    <= 1'b0;
            ALUSrcA  <= 1'b0;
            ALUSrcB  <= SRCB_REG;
            PCSrc    <= PCSRC_ALU;
            AddrSrc  <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            RegWrite <= 1'b0;
            WBSrc    <= 1'b0;
            Halted   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            ALUOp    <= dec_alu_op;
            ALUEn    <= dec_alu_en;
            ALUSrcA  <= dec_alu_src_a;
            ALUSrcB  <= dec_alu_src_b;
            PCSrc    <= (state_nxt == S_BRANCH) ? PCSRC_BRANCH :
                        (state_nxt == S_JUMP)   ? PCSRC_JUMP   : PCSRC_ALU;
            AddrSrc  <= (state_nxt == S_MEM_RD) || (state_nxt == S_MEM_WR);
            MemRead  <= (state_nxt == S_FETCH) || (state_nxt == S_MEM_RD);
            MemWrite <= (state_nxt == S_MEM_WR);
            RegWrite <= (state_nxt == S_WB_ALU) || (state_nxt == S_WB_MEM);
            WBSrc    <= (state_nxt == S_WB_MEM);
            Halted   <= (state_nxt == S_HALT);
        end
    end

    // Strobes that depend on same-cycle MemReady, flags or opcode stay combinational.
    assign IRWrite = (state_q == S_FETCH) && MemReady;
    assign PCWrite = ((state_q == S_FETCH) && MemReady)
                   || ((state_q == S_BRANCH) && ((Opcode == OP_BLT) ? N : Z))
                   || (state_q == S_JUMP);
    assign Illegal = (state_q == S_DECODE) && !op_is_legal(Opcode);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
    import multicycle_control_fsm_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] Opcode;
    logic       Z;
    logic       N;
    logic       MemReady;
    logic [2:0] ALUOp;
    logic       ALUEn;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       IRWrite;
    logic       AddrSrc;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       WBSrc;
    logic       Halted;
    logic       Illegal;

    int errors = 0;
    int checks = 0;

    multicycle_control_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Opcode   (Opcode),
        .Z        (Z),
        .N        (N),
        .MemReady (MemReady),
        .ALUOp    (ALUOp),
        .ALUEn    (ALUEn),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .PCWrite  (PCWrite),
        .PCSrc    (PCSrc),
        .IRWrite  (IRWrite),
        .AddrSrc  (AddrSrc),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .WBSrc    (WBSrc),
        .Halted   (Halted),
        .Illegal  (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] outs;
    assign outs = {ALUOp, ALUEn, ALUSrcA, ALUSrcB, PCWrite, PCSrc, IRWrite,
                   AddrSrc, MemRead, MemWrite, RegWrite, WBSrc, Halted, Illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [2:0] aop, input logic en, input logic sa,
                                       input logic [1:0] sb, input logic pcw, input logic [1:0] pcs,
                                       input logic irw, input logic ad, input logic mr, input logic mw,
                                       input logic rw, input logic wb, input logic hl, input logic il);
        return {aop, en, sa, sb, pcw, pcs, irw, ad, mr, mw, rw, wb, hl, il};
    endfunction

    function automatic logic [17:0] e_fetch(input logic rdy);
        return mk(3'b000, 1, 0, 2'b01, rdy, 2'b00, rdy, 0, 1, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] e_exec_r(input logic [2:0] aop);
        return mk(aop, 1, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] e_imm();
        return mk(3'b000, 1, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [17:0] e_branch(input logic taken);
        return mk(3'b001, 1, 1, 2'b00, taken, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    localparam logic [17:0] E_ZERO    = 18'd0;
    localparam logic [17:0] E_WB_ALU  = 18'b000_0_0_00_0_00_0_0_0_0_1_0_0_0;
    localparam logic [17:0] E_WB_MEM  = 18'b000_0_0_00_0_00_0_0_0_0_1_1_0_0;
    localparam logic [17:0] E_MEM_RD  = 18'b000_0_0_00_0_00_0_1_1_0_0_0_0_0;
    localparam logic [17:0] E_MEM_WR  = 18'b000_0_0_00_0_00_0_1_0_1_0_0_0_0;
    localparam logic [17:0] E_JUMP    = 18'b000_0_0_00_1_10_0_0_0_0_0_0_0_0;
    localparam logic [17:0] E_HALT    = 18'b000_0_0_00_0_00_0_0_0_0_0_0_1_0;
    localparam logic [17:0] E_ILLEGAL = 18'b000_0_0_00_0_00_0_0_0_0_0_0_0_1;

    // Inputs are set at the falling edge; checks land 1ns later, mid-cycle.
    task automatic cyc(input string tag, input state_t st, input logic [17:0] ev);
        #1;
        check({tag, ".state"}, 32'(dut.state_q), 32'(st));
        check({tag, ".outs"}, 32'(outs), 32'(ev));
        @(negedge clk);
    endtask

    task automatic fetch_decode(input logic [3:0] op, input string tag);
        Opcode   = op;
        MemReady = 1'b1;
        cyc({tag, ".fetch"}, S_FETCH, e_fetch(1'b1));
        cyc({tag, ".decode"}, S_DECODE, E_ZERO);
    endtask

    task automatic alu_instr(input logic [3:0] op, input string tag);
        fetch_decode(op, tag);
        cyc({tag, ".exec"}, S_EXEC_R, e_exec_r(op[2:0]));
        cyc({tag, ".wb"}, S_WB_ALU, E_WB_ALU);
    endtask

    task automatic branch_instr(input logic [3:0] op, input logic z, input logic n,
                                input logic taken, input string tag);
        Z = z;
        N = n;
        fetch_decode(op, tag);
        cyc({tag, ".branch"}, S_BRANCH, e_branch(taken));
    endtask

    initial begin
        rst_n    = 1'b0;
        Opcode   = OP_ADD;
        Z        = 1'b0;
        N        = 1'b0;
        MemReady = 1'b1;
        repeat (2) @(negedge clk);
        cyc("reset", S_IDLE, E_ZERO);
        rst_n = 1'b1;
        cyc("idle", S_IDLE, E_ZERO);

        alu_instr(OP_ADD, "add");
        alu_instr(OP_SUB, "sub");
        alu_instr(OP_XOR, "xor");

        Opcode   = OP_ADDI;
        MemReady = 1'b0;
        cyc("fetchwait0", S_FETCH, e_fetch(1'b0));
        cyc("fetchwait1", S_FETCH, e_fetch(1'b0));
        fetch_decode(OP_ADDI, "addi");
        cyc("addi.exec", S_EXEC_I, e_imm());
        cyc("addi.wb", S_WB_ALU, E_WB_ALU);

        fetch_decode(OP_LW, "lw");
        cyc("lw.addr", S_MEM_ADDR, e_imm());
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("lw.wait%0d", i), S_MEM_RD, E_MEM_RD);
        MemReady = 1'b1;
        cyc("lw.rd", S_MEM_RD, E_MEM_RD);
        cyc("lw.wb", S_WB_MEM, E_WB_MEM);

        fetch_decode(OP_SW, "sw");
        cyc("sw.addr", S_MEM_ADDR, e_imm());
        cyc("sw.wr", S_MEM_WR, E_MEM_WR);

        branch_instr(OP_BEQ, 1'b1, 1'b0, 1'b1, "beq_t");
        branch_instr(OP_BEQ, 1'b0, 1'b1, 1'b0, "beq_nt");
        branch_instr(OP_BLT, 1'b0, 1'b1, 1'b1, "blt_t");
        branch_instr(OP_BLT, 1'b1, 1'b0, 1'b0, "blt_nt");
        Z = 1'b0;
        N = 1'b0;

        fetch_decode(OP_JMP, "jmp");
        cyc("jmp.jump", S_JUMP, E_JUMP);

        Opcode = 4'b1100;
        cyc("ill.fetch", S_FETCH, e_fetch(1'b1));
        cyc("ill.decode", S_DECODE, E_ILLEGAL);

        fetch_decode(OP_SW, "swrst");
        cyc("swrst.addr", S_MEM_ADDR, e_imm());
        MemReady = 1'b0;
        cyc("swrst.wait0", S_MEM_WR, E_MEM_WR);
        cyc("swrst.wait1", S_MEM_WR, E_MEM_WR);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async.state", 32'(dut.state_q), 32'(S_IDLE));
        check("rst_async.outs", 32'(outs), 32'(E_ZERO));
        @(negedge clk);
        cyc("rst_hold", S_IDLE, E_ZERO);
        rst_n    = 1'b1;
        MemReady = 1'b1;
        cyc("rst_idle", S_IDLE, E_ZERO);
        alu_instr(OP_OR, "or");

        fetch_decode(OP_HALT, "halt");
        for (int i = 0; i < 20; i++) begin
            MemReady = i[0];
            Z        = ~i[0];
            N        = i[1];
            cyc($sformatf("halt%0d", i), S_HALT, E_HALT);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
